vga_pixel_fetch: RTL and testbench

- Downstream consumer of the two sync/position generators (horizontal and vertical instances).
- Turns their active-video flags and pixel positions into frame-buffer read addresses for the leaf image window.
- Returns 12-bit RGB aligned with delayed sync, plus a top banner coloured by the latest classifier label.
- Labels are double-buffered so a label never changes mid-frame.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_pixel_fetch.sv | 180 ++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared pixel types, banner palette and pipeline flag bundle for
//            the VGA pixel-fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int RGB_W = 12;

    typedef logic [RGB_W-1:0] pix_t;

    localparam pix_t BORDER = 12'h222;

    // Indexed by classifier label: healthy, blight, rust, mildew, spot,
    // mosaic, scab, unknown.
    localparam pix_t PALETTE [0:7] = '{
        12'h0F0, 12'hA50, 12'hF80, 12'hCCC,
        12'h840, 12'hFF0, 12'h555, 12'hF00
    };

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic win;
        logic ban;
    } vid_flags_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Purpose  : Fixed-depth shift register, cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : vga_delay_line
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_fetch
// Purpose  : Maps sync-generator positions to frame-buffer reads for the
//            upscaled image window, and muxes image, label banner and border.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter logic [10:0] IMG_X0     = 11'd192,
    parameter logic [10:0] IMG_Y0     = 11'd112,
    parameter int          IMG_W      = 128,
    parameter int          IMG_H      = 128,
    parameter int          SCALE_LOG2 = 1,
    parameter int          RD_LAT     = 2,
    parameter logic [10:0] BANNER_H   = 11'd16,
    parameter int          ADDR_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_free,
    input  logic              v_free,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic [10:0]       h_pos,
    input  logic [10:0]       v_pos,
    input  logic [2:0]        label_in,
    input  logic              label_valid,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [11:0]       fb_data,
    output logic [11:0]       vga_rgb,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              frame_start
);

    localparam int          AW1      = ADDR_W + 1;
    localparam int          SUB_W    = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [10:0] X_END    = IMG_X0 + 11'(IMG_W << SCALE_LOG2);
    localparam logic [10:0] Y_END    = IMG_Y0 + 11'(IMG_H << SCALE_LOG2);
    localparam logic [AW1-1:0] MAX_ADDR = AW1'(IMG_W * IMG_H - 1);
    localparam logic [AW1-1:0] ROW_STEP = AW1'(IMG_W);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam int          FLAG_W   = $bits(vid_flags_t);

    // Stage 0 decode
    logic w_act, w_in_win, w_in_ban, w_win_fall;

    always_comb begin
        w_act    = h_free & v_free;
        w_in_win = w_act && (h_pos >= IMG_X0) && (h_pos < X_END)
                         && (v_pos >= IMG_Y0) && (v_pos < Y_END);
        w_in_ban = w_act && (v_pos < BANNER_H);
    end

    // Address generation state
    logic              v_free_q, frame_start_q, in_win_q, fb_rd_q;
    logic [10:0]       col_cnt_q, col_cnt_d;
    logic [SUB_W-1:0]  line_sub_q, line_sub_d, w_sub_inc;
    logic [AW1-1:0]    row_base_q, row_base_d, w_row_next;
    logic [AW1-1:0]    w_col_off, w_sum, w_addr;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]        label_pend_q, label_pend_d, label_act_q, label_act_d;
    logic              pend_valid_q, pend_valid_d;

    assign w_win_fall = in_win_q & ~w_in_win;

    always_comb begin
        w_col_off  = AW1'(col_cnt_q >> SCALE_LOG2);
        w_sum      = row_base_q + w_col_off;
        w_addr     = (w_sum > MAX_ADDR) ? MAX_ADDR : w_sum;
        fb_addr_d  = w_in_win ? w_addr[ADDR_W-1:0] : fb_addr_q;
        col_cnt_d  = w_in_win ? col_cnt_q + 11'd1 : 11'd0;

        w_sub_inc  = (line_sub_q == SUB_MAX) ? '0 : line_sub_q + 1'b1;
        w_row_next = row_base_q + ROW_STEP;
        line_sub_d = line_sub_q;
        row_base_d = row_base_q;
        if (frame_start_q) begin
            line_sub_d = '0;
            row_base_d = '0;
        end else if (w_win_fall) begin
            line_sub_d = w_sub_inc;
            // Each source row is shown on 2^SCALE_LOG2 display lines.
            if (w_sub_inc == '0) begin
                row_base_d = (w_row_next > MAX_ADDR) ? MAX_ADDR : w_row_next;
            end
        end
    end

    // Labels only become visible at a frame boundary; a strobe landing on
    // frame_start still queues behind the value being transferred.
    always_comb begin
        label_pend_d = label_pend_q;
        label_act_d  = label_act_q;
        pend_valid_d = pend_valid_q;
        if (frame_start_q && pend_valid_q) begin
            label_act_d  = label_pend_q;
            pend_valid_d = 1'b0;
        end
        if (label_valid) begin
            label_pend_d = label_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_free_q      <= 1'b0;
            frame_start_q <= 1'b0;
            in_win_q      <= 1'b0;
            fb_rd_q       <= 1'b0;
            fb_addr_q     <= '0;
            col_cnt_q     <= '0;
            line_sub_q    <= '0;
            row_base_q    <= '0;
            label_pend_q  <= '0;
            label_act_q   <= '0;
            pend_valid_q  <= 1'b0;
        end else begin
            v_free_q      <= v_free;
            frame_start_q <= v_free_q & ~v_free;
            in_win_q      <= w_in_win;
            fb_rd_q       <= w_in_win;
            fb_addr_q     <= fb_addr_d;
            col_cnt_q     <= col_cnt_d;
            line_sub_q    <= line_sub_d;
            row_base_q    <= row_base_d;
            label_pend_q  <= label_pend_d;
            label_act_q   <= label_act_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

    // Flags travel alongside the read so they line up with fb_data.
    vid_flags_t        w_flags, w_flags_dly;
    logic [FLAG_W-1:0] w_dly_bits;

    always_comb begin
        w_flags.hs  = h_sync;
        w_flags.vs  = v_sync;
        w_flags.act = w_act;
        w_flags.win = w_in_win;
        w_flags.ban = w_in_ban;
    end

    vga_delay_line #(
        .WIDTH (FLAG_W),
        .DEPTH (1 + RD_LAT)
    ) u_flag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (w_flags),
        .q_o   (w_dly_bits)
    );

    assign w_flags_dly = w_dly_bits;

    pix_t w_rgb;

    always_comb begin
        w_rgb = '0;
        if (w_flags_dly.act) begin
            if (w_flags_dly.ban)      w_rgb = PALETTE[label_act_q];
            else if (w_flags_dly.win) w_rgb = fb_data;
            else                      w_rgb = BORDER;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_rd       = fb_rd_q;
    assign vga_rgb     = w_rgb;
    assign vga_hs      = w_flags_dly.hs;
    assign vga_vs      = w_flags_dly.vs;
    assign frame_start = frame_start_q;

endmodule : vga_pixel_fetch
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_fetch
// Purpose  : Directed self-checking bench for vga_pixel_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_fetch;

    localparam int HIST = 16384;
    localparam int ACT  = 464;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_free = 1'b0, v_free = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
    logic [10:0] h_pos = '0, v_pos = '0;
    logic [2:0]  label_in = '0;
    logic        label_valid = 1'b0;
    logic [13:0] fb_addr;
    logic        fb_rd;
    logic [11:0] fb_data;
    logic [11:0] vga_rgb;
    logic        vga_hs, vga_vs, frame_start;

    logic [13:0] rd_p1 = '0, rd_p2 = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic prev_vf = 1'b0;
    logic [11:0] exp_ban = 12'h000;

    logic [11:0] e_rgb [0:HIST-1];
    logic        e_hs  [0:HIST-1];
    logic        e_vs  [0:HIST-1];

    vga_pixel_fetch u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_free      (h_free),
        .v_free      (v_free),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .h_pos       (h_pos),
        .v_pos       (v_pos),
        .label_in    (label_in),
        .label_valid (label_valid),
        .fb_addr     (fb_addr),
        .fb_rd       (fb_rd),
        .fb_data     (fb_data),
        .vga_rgb     (vga_rgb),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input logic [13:0] a);
        return a[11:0] ^ {a[13:12], 10'h2A5};
    endfunction

    // Frame-buffer model: data follows the address by two cycles.
    always @(posedge clk) begin
        rd_p1 <= fb_addr;
        rd_p2 <= rd_p1;
    end
    assign fb_data = pat(rd_p2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One pixel clock of stimulus; rb is the hand-computed row base of the line.
    task automatic drive(input logic hf, input logic vf, input logic [10:0] hp,
                         input logic [10:0] vp, input logic [13:0] rb,
                         input logic lv, input logic [2:0] li);
        logic act, win, ban;
        logic [13:0] ea;
        h_free = hf; v_free = vf; h_pos = hp; v_pos = vp;
        label_valid = lv; label_in = li;
        h_sync = 1'($urandom_range(0, 1));
        v_sync = 1'($urandom_range(0, 1));
        act = hf & vf;
        win = act && hp >= 11'd192 && hp < 11'd448 && vp >= 11'd112 && vp < 11'd368;
        ban = act && vp < 11'd16;
        ea  = rb + 14'((hp - 11'd192) >> 1);
        e_rgb[cyc] = ban ? exp_ban : win ? pat(ea) : act ? 12'h222 : 12'h000;
        e_hs[cyc]  = h_sync;
        e_vs[cyc]  = v_sync;
        @(posedge clk);
        #1;
        check("fb_rd", fb_rd, win);
        if (win) check("fb_addr", fb_addr, ea);
        check("frame_start", frame_start, prev_vf & ~vf);
        prev_vf = vf;
        if (cyc >= 2) begin
            check("vga_rgb", vga_rgb, e_rgb[cyc-2]);
            check("vga_hs",  vga_hs,  e_hs[cyc-2]);
            check("vga_vs",  vga_vs,  e_vs[cyc-2]);
        end
        if (cyc < HIST - 1) cyc++;
    endtask

    task automatic line(input logic [10:0] vp, input logic [13:0] rb);
        for (int h = 0; h < ACT; h++) drive(1'b1, 1'b1, 11'(h), vp, rb, 1'b0, 3'd0);
        for (int b = 0; b < 6; b++)   drive(1'b0, 1'b1, 11'd0, vp, rb, 1'b0, 3'd0);
    endtask

    task automatic frame(input logic full, input int n_strobe, input logic [2:0] s0,
                         input logic [2:0] s1, input logic end_lv, input logic [2:0] end_li);
        line(11'd0, 14'd0);
        if (full) begin
            line(11'd60, 14'd0);
            if (n_strobe > 0) drive(1'b0, 1'b1, 11'd0, 11'd60, 14'd0, 1'b1, s0);
            if (n_strobe > 1) drive(1'b0, 1'b1, 11'd0, 11'd60, 14'd0, 1'b1, s1);
            line(11'd112, 14'd0);
            line(11'd113, 14'd0);
            line(11'd114, 14'd128);
            line(11'd115, 14'd128);
        end
        drive(1'b0, 1'b0, 11'd0, 11'd0, 14'd0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 11'd0, 11'd0, 14'd0, end_lv, end_li);
        drive(1'b0, 1'b0, 11'd0, 11'd0, 14'd0, 1'b0, 3'd0);
    endtask

    initial begin
        #2;
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_rd", fb_rd, 0);
        check("rst_vga_rgb", vga_rgb, 0);
        check("rst_vga_hs", vga_hs, 0);
        check("rst_vga_vs", vga_vs, 0);
        check("rst_frame_start", frame_start, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 11'd0, 11'd0, 14'd0, 1'b0, 3'd0);

        exp_ban = 12'h0F0;
        frame(1'b1, 1, 3'd3, 3'd0, 1'b0, 3'd0);
        exp_ban = 12'hCCC;
        frame(1'b1, 2, 3'd2, 3'd5, 1'b1, 3'd6);
        exp_ban = 12'hFF0;
        frame(1'b0, 0, 3'd0, 3'd0, 1'b0, 3'd0);
        exp_ban = 12'h555;
        frame(1'b0, 0, 3'd0, 3'd0, 1'b0, 3'd0);

        for (int h = 188; h < 200; h++) drive(1'b1, 1'b1, 11'(h), 11'd112, 14'd0, 1'b0, 3'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_fb_addr", fb_addr, 0);
        check("async_fb_rd", fb_rd, 0);
        check("async_vga_rgb", vga_rgb, 0);
        check("async_vga_hs", vga_hs, 0);
        check("async_vga_vs", vga_vs, 0);
        check("async_frame_start", frame_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vga_pixel_fetch
`default_nettype wire
